// File: rtl/aes_pkg.sv
// Shared AES arithmetic (GF(2^8), S-box, MixColumns), the round-constant table,
// the FSM state type, and helpers that derive the round and word counts from Nk.
package aes_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_ROUND, ST_DONE} aes_state_e;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic int nw_of(input int nk);
    return 4 * (nk + 7);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // The S-box is computed as inverse (x^254) followed by the affine map;
  // zero maps to zero under x^254, which gives the required 0x63 for input 0.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv, base;
    inv  = 8'h01;
    base = b;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gf_mul(inv, base);
      base = gf_mul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Rcon[i] for i in 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return RCON[i - 4'd1];
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES round, purely combinational: SubBytes, ShiftRows, optional MixColumns,
// then AddRoundKey. Byte b sits at [127-8b -: 8], column-major.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [7:0]   sb [16];
  logic [127:0] sr, mc;

  always_comb begin
    sr = '0;
    mc = '0;
    for (int b = 0; b < 16; b++) sb[b] = sbox(state[127-8*b -: 8]);
    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    next_state = (final_round ? sr : mc) ^ rk;
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryptor: one key-expansion word per cycle into a
// round-key file, then one round per cycle per block, with valid/ready on both sides.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_load,
  input  logic [32*Nk-1:0] key,
  output logic            key_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    plain_text,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    cipher_text,
  output logic            busy
);

  localparam int Nr = nr_of(Nk);
  localparam int NW = nw_of(Nk);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_iter_core: Nk must be 4, 6 or 8");
  end

  aes_state_e             state_q, state_d;
  logic [NW-1:0][31:0]    rk_q, rk_d;
  logic [5:0]             wcnt_q, wcnt_d;
  logic [2:0]             kmod_q, kmod_d;
  logic [3:0]             rci_q, rci_d;
  logic [3:0]             rnd_q, rnd_d;
  logic [127:0]           st_q, st_d;
  logic [127:0]           ct_q, ct_d;
  logic                   ov_q, ov_d;
  logic                   kr_q, kr_d;

  logic [31:0]  w_prev, w_back, w_f;
  logic [127:0] rk_cur, rk0, rnd_out;

  always_comb begin
    w_prev = rk_q[wcnt_q - 6'd1];
    w_back = rk_q[wcnt_q - 6'(Nk)];
    if (kmod_q == 3'd0)
      w_f = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(rci_q), 24'h0};
    else if (Nk == 8 && kmod_q == 3'd4)
      w_f = sub_word(w_prev);
    else
      w_f = w_prev;
    rk0    = {rk_q[0], rk_q[1], rk_q[2], rk_q[3]};
    rk_cur = '0;
    for (int j = 0; j < 4; j++) rk_cur[127-32*j -: 32] = rk_q[{rnd_q, 2'b00} + 6'(j)];
  end

  aes_round_comb u_round (
    .state      (st_q),
    .rk         (rk_cur),
    .final_round(rnd_q == 4'(Nr)),
    .next_state (rnd_out)
  );

  assign in_ready    = (state_q == ST_IDLE) && kr_q && !key_load;
  assign busy        = (state_q != ST_IDLE);
  assign key_ready   = kr_q;
  assign out_valid   = ov_q;
  assign cipher_text = ct_q;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    wcnt_d  = wcnt_q;
    kmod_d  = kmod_q;
    rci_d   = rci_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    ct_d    = ct_q;
    ov_d    = ov_q;
    kr_d    = kr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          for (int j = 0; j < Nk; j++) rk_d[j] = key[32*(Nk-j)-1 -: 32];
          kr_d    = 1'b0;
          wcnt_d  = 6'(Nk);
          kmod_d  = 3'd0;
          rci_d   = 4'd1;
          state_d = ST_EXPAND;
        end else if (in_valid && in_ready) begin
          st_d    = plain_text ^ rk0;
          rnd_d   = 4'd1;
          state_d = ST_ROUND;
        end
      end
      ST_EXPAND: begin
        rk_d[wcnt_q] = w_back ^ w_f;
        wcnt_d = wcnt_q + 6'd1;
        if (kmod_q == 3'(Nk - 1)) begin
          kmod_d = 3'd0;
          rci_d  = rci_q + 4'd1;
        end else begin
          kmod_d = kmod_q + 3'd1;
        end
        if (wcnt_q == 6'(NW - 1)) begin
          kr_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        st_d  = rnd_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(Nr)) begin
          ct_d    = rnd_out;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      wcnt_q  <= '0;
      kmod_q  <= '0;
      rci_q   <= '0;
      rnd_q   <= '0;
      st_q    <= '0;
      ct_q    <= '0;
      ov_q    <= 1'b0;
      kr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      wcnt_q  <= wcnt_d;
      kmod_q  <= kmod_d;
      rci_q   <= rci_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      ov_q    <= ov_d;
      kr_q    <= kr_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboarded bench for AES-128/192/256 instances sharing one clock and reset:
// expected ciphertext and accept cycle are queued on handshake, checked on out_valid rise.
module tb_aes_iter_core;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] key_load, in_valid, out_ready, key_ready, in_ready, out_valid, busy;
  logic [255:0] keyv [3];
  logic [127:0] pt [3];
  logic [127:0] ct [3];

  typedef struct { int d; logic [127:0] ct; int acc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   nrs [3] = '{10, 12, 14};
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [2:0] ov_prev = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_iter_core #(.Nk(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_load(key_load[0]), .key(keyv[0][255 -: 128]),
    .key_ready(key_ready[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .plain_text(pt[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .cipher_text(ct[0]), .busy(busy[0]));

  aes_iter_core #(.Nk(6)) u_dut6 (
    .clk(clk), .rst(rst), .key_load(key_load[1]), .key(keyv[1][255 -: 192]),
    .key_ready(key_ready[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .plain_text(pt[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .cipher_text(ct[1]), .busy(busy[1]));

  aes_iter_core #(.Nk(8)) u_dut8 (
    .clk(clk), .rst(rst), .key_load(key_load[2]), .key(keyv[2]),
    .key_ready(key_ready[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .plain_text(pt[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .cipher_text(ct[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: every rise of out_valid must match the oldest queued block.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (out_valid[d] && !ov_prev[d]) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 128'(out_valid[d]), 128'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_inst", 128'(d), 128'(mon_e.d));
          chk("cipher", ct[d], mon_e.ct);
          chk("latency", 128'(cyc - mon_e.acc), 128'(nrs[d]));
        end
      end
    end
    ov_prev <= out_valid;
  end

  task automatic wait_kr(input int d, input int t0, input int exp_lat);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (key_ready[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("kr_timeout", 128'(ok), 128'd1);
    chk("kr_latency", 128'(cyc - t0), 128'(exp_lat));
  endtask

  task automatic load_key(input int d, input logic [255:0] k, input int exp_lat);
    int t0;
    @(negedge clk);
    keyv[d] = k;
    key_load[d] = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    key_load[d] = 1'b0;
    wait_kr(d, t0, exp_lat);
  endtask

  // Returns at the negedge following the accept edge, with in_valid dropped.
  task automatic send(input int d, input logic [127:0] p, input logic [127:0] c);
    bit ok = 1'b0;
    @(negedge clk);
    pt[d] = p;
    in_valid[d] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (in_ready[d]) begin
        sb.push_back('{d, c, cyc + 1});
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk("accept_timeout", 128'(ok), 128'd1);
  endtask

  task automatic drain(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid[d]) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", 128'(ok), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [3];
    int cnt;
    int t0;
    bit flag;
    key_load  = '0;
    in_valid  = '0;
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin keyv[d] = '0; pt[d] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_cipher", ct[0], 128'd0);
    rst = 1'b0;

    // FIPS-197 appendix vectors, 128-bit
    load_key(0, {K1, 128'h0}, 40);
    send(0, P1, C1);
    drain(0);

    // Consumer stall: output held, no new block accepted
    load_key(0, {K2, 128'h0}, 40);
    out_ready[0] = 1'b0;
    send(0, P2, C2);
    flag = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid[0]) begin flag = 1'b1; break; end
      @(negedge clk);
    end
    chk("stall_timeout", 128'(flag), 128'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid[0]), 128'd1);
      chk("hold_cipher", ct[0], C2);
      chk("hold_in_ready", 128'(in_ready[0]), 128'd0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 128'(out_valid[0]), 128'd0);
    chk("cipher_kept", ct[0], C2);

    // 192- and 256-bit keys
    load_key(1, {K6, 64'h0}, 46);
    send(1, P2, C6);
    drain(1);
    load_key(2, K8, 52);
    send(2, P2, C8);
    drain(2);

    // Back-to-back blocks, one accept every Nr+2 cycles
    @(negedge clk);
    pt[0] = P2;
    in_valid[0] = 1'b1;
    cnt = 0;
    flag = 1'b0;
    for (int i = 0; i < 100 && cnt < 3; i++) begin
      #1;
      if (!key_ready[0]) flag = 1'b1;
      if (in_ready[0]) begin
        sb.push_back('{0, C2, cyc + 1});
        acc[cnt] = cyc + 1;
        cnt++;
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    chk("b2b_count", 128'(cnt), 128'd3);
    chk("b2b_gap1", 128'(acc[1] - acc[0]), 128'd12);
    chk("b2b_gap2", 128'(acc[2] - acc[1]), 128'd12);
    chk("b2b_key_ready_drop", 128'(flag), 128'd0);
    drain(0);

    // key_load beats in_valid in IDLE
    @(negedge clk);
    keyv[0] = {K1, 128'h0};
    pt[0] = P1;
    key_load[0] = 1'b1;
    in_valid[0] = 1'b1;
    t0 = cyc + 1;
    #1;
    chk("kl_prio_in_ready", 128'(in_ready[0]), 128'd0);
    @(negedge clk);
    key_load[0] = 1'b0;
    in_valid[0] = 1'b0;
    chk("kl_prio_busy", 128'(busy[0]), 128'd1);
    chk("kl_prio_key_ready", 128'(key_ready[0]), 128'd0);
    wait_kr(0, t0, 40);

    // key_load during ROUND is dropped; block finishes under the old key
    send(0, P1, C1);
    keyv[0] = {K2, 128'h0};
    key_load[0] = 1'b1;
    @(negedge clk);
    key_load[0] = 1'b0;
    drain(0);
    chk("kl_round_key_ready", 128'(key_ready[0]), 128'd1);
    send(0, P1, C1);
    drain(0);

    // Asynchronous reset mid-ROUND
    send(0, P1, C1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("rr_key_ready", 128'(key_ready), 128'd0);
    chk("rr_out_valid", 128'(out_valid), 128'd0);
    chk("rr_busy", 128'(busy), 128'd0);
    chk("rr_in_ready", 128'(in_ready), 128'd0);
    chk("rr_cipher", ct[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b1;
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready[0]) flag = 1'b1;
    end
    in_valid[0] = 1'b0;
    chk("post_rst_in_ready", 128'(flag), 128'd0);

    // Asynchronous reset mid-EXPAND
    @(negedge clk);
    keyv[0] = {K1, 128'h0};
    key_load[0] = 1'b1;
    @(negedge clk);
    key_load[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_expand_busy", 128'(busy[0]), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("re_busy", 128'(busy[0]), 128'd0);
    chk("re_key_ready", 128'(key_ready[0]), 128'd0);
    chk("re_in_ready", 128'(in_ready[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("re_no_key_ready", 128'(key_ready[0]), 128'd0);
    load_key(0, {K1, 128'h0}, 40);
    send(0, P1, C1);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Iterative, clocked AES encryption core generalised to AES-128/192/256 through parameter Nk.
- Expands a loaded key once into an on-chip round-key register file, one word per cycle.
- Then encrypts any number of 128-bit blocks under that key, one round per cycle, with valid/ready handshakes on input and output.
- Sequential successor to the combinational unrolled encryptor; intended for area-constrained top levels.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8. Any other value is a compile-time error.
- Nr, Nk+6, number of rounds. Derived; must not be overridden.
- NW, 4*(Nr+1), total round-key words. Derived.

Ports:
- clk  in  1  clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- key_load  in  1  one-cycle request to load key and start expansion.
- key  in  32*Nk  cipher key; word 0 = key[32*Nk-1 -: 32].
- key_ready  out  1  round keys valid for the current key.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  core accepts plaintext this cycle.
- plain_text  in  128  block; byte 0 at [127:120], FIPS-197 column-major order.
- out_valid  out  1  cipher_text valid.
- out_ready  in  1  consumer takes cipher_text.
- cipher_text  out  128  result; same byte order as plain_text.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: all of the following are cleared:
  - FSM goes to IDLE.
  - key_ready=0, out_valid=0, cipher_text=0, busy=0, in_ready=0.
  - Round-key file and state register go to 0.
- Reset mid-expansion or mid-encryption aborts the operation. No output is produced afterwards.
- FSM states: IDLE, EXPAND, ROUND, DONE.
- IDLE:
  - key_load=1 → EXPAND. Words 0..Nk-1 are written from key on that edge, key_ready←0, word counter←Nk.
  - key_load has priority over in_valid.
- EXPAND:
  - One word per cycle: w[i] = w[i-Nk] ^ f(w[i-1]).
  - f = SubWord(RotWord)^Rcon[i/Nk] when i%Nk==0.
  - f = SubWord only when Nk==8 and i%Nk==4.
  - Otherwise f is identity.
  - After writing word NW-1 → IDLE with key_ready←1.
  - Expansion takes NW-Nk cycles after the load edge: 40 / 46 / 52 cycles for Nk 4 / 6 / 8.
  - key_load is ignored while in EXPAND.
- in_ready = (state==IDLE) && key_ready && !key_load. This is combinational.
- Handshake on edge T (in_valid && in_ready):
  - state ← plain_text ^ RK0, round←1 → ROUND.
- ROUND, edges T+1..T+Nr:
  - For round r<Nr: SubBytes, ShiftRows, MixColumns, then ^RKr.
  - For round r==Nr: MixColumns is omitted.
  - After edge T+Nr → DONE. cipher_text is registered and out_valid←1.
  - Latency is Nr cycles from the accept edge to out_valid: 10 / 12 / 14.
- Round key RKr = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.
- DONE:
  - out_valid and cipher_text are held stable until out_ready=1.
  - On that edge out_valid←0 → IDLE.
  - cipher_text keeps its last value after the handshake.
  - No new block is accepted in DONE; throughput is one block per Nr+2 cycles with out_ready held high.
- key_load in ROUND or DONE is ignored; it is not queued. The key in use never changes mid-block.
- in_valid while in_ready=0 carries no obligation. The producer holds plain_text until it sees the handshake.
- key_ready stays 1 across any number of encryptions until the next key_load or reset.

Decomposition:
- Package aes_pkg holds:
  - S-box as a function.
  - xtime and MixColumns-column functions.
  - Rcon table (10 entries).
  - FSM state enum.
  - Nr/NW derivation functions.
- One sub-module aes_round_comb contains:
  - Inputs state[127:0], rk[127:0], final_round; output next_state[127:0].
  - Purely combinational, built on the existing SubBytes and ShiftRows plus a MixColumns stage bypassed when final_round=1.
- Key-expansion word logic stays inline in the core.

Test Plan:
1. Nk=4: load key 2b7e151628aed2a6abf7158809cf4f3c, wait for key_ready (40 cycles), encrypt 3243f6a8885a308d313198a2e0370734 → cipher 3925841d02dc09fbdc118597196a0b32 exactly 10 cycles after the accept edge.
2. Nk=4, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Then hold out_ready=0 for 5 cycles: out_valid and cipher_text must stay stable and in_ready=0.
3. Nk=6, key 000102…1617, same pt → dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles. Nk=8, key 000102…1e1f → 8ea2b7ca516745bfeafc49904b496089 after 14 cycles; key_ready rises after 52 cycles.
4. Back-to-back blocks under one key with out_ready=1 → correct results, one block per 12 cycles (Nk=4), key_ready never drops.
5. Assert key_load and in_valid together in IDLE → in_ready=0, expansion starts. Assert key_load during ROUND → ignored and the block completes with the old key.
6. Assert rst mid-ROUND and mid-EXPAND → all outputs 0 immediately (asynchronously). in_ready stays 0 until a fresh key_load completes.
